// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: 25xx-style SPI EEPROM target, 8-bit addressing.
// Serves READ/WRITE/WREN/WRDI/RDSR from an internal array, plus a host load port.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   spi_cs_n/sck/copi   SPI mode 0 inputs, asynchronous to clk
//   spi_cipo/cipo_oe    SPI data out and its drive enable
//   load_en/addr/data   host preload write, honoured only while idle
//   wel                 write-enable latch (status bit 1)
module spi_eeprom_responder #(
    parameter int DEPTH = 256,
    parameter int PAGE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic       spi_copi,
    output logic       spi_cipo,
    output logic       spi_cipo_oe,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic       wel
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PMASK = AW'(PAGE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_RDSR   = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    logic [7:0]    mem [DEPTH];
    logic [2:0]    cs_sy;
    logic [2:0]    sck_sy;
    logic [1:0]    copi_sy;
    logic [2:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    rx_sh;
    logic [7:0]    tx_sh;
    logic [AW-1:0] ptr;
    logic          wrote;
    logic          is_rd;
    logic          armed;

    // [1] is the synchronized level, [2] its previous value for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sy   <= 3'b111;
            sck_sy  <= 3'b000;
            copi_sy <= 2'b00;
        end else begin
            cs_sy   <= {cs_sy[1:0], spi_cs_n};
            sck_sy  <= {sck_sy[1:0], spi_sck};
            copi_sy <= {copi_sy[0], spi_copi};
        end
    end

    logic          cs_fall;
    logic          cs_rise;
    logic          sck_rise;
    logic          sck_fall;
    logic          byte_done;
    logic [2:0]    bit_dec;
    logic [7:0]    rx_nxt;
    logic [7:0]    status;
    logic [AW-1:0] rx_addr;
    logic [AW-1:0] ptr_inc;
    logic [AW-1:0] ptr_pg;
    logic          spi_we;
    logic          load_we;

    assign cs_fall   = cs_sy[2] & ~cs_sy[1];
    assign cs_rise   = ~cs_sy[2] & cs_sy[1];
    assign sck_rise  = ~sck_sy[2] & sck_sy[1];
    assign sck_fall  = sck_sy[2] & ~sck_sy[1];
    assign byte_done = (bitcnt == 3'd0);
    assign bit_dec   = bitcnt - 3'd1;
    assign rx_nxt    = {rx_sh[6:0], copi_sy[1]};
    assign rx_addr   = rx_nxt[AW-1:0];
    assign status    = {6'b0, wel, 1'b0};
    assign ptr_inc   = ptr + AW'(1);
    // Page-wrapping increment: only the in-page bits advance.
    assign ptr_pg    = (ptr & ~PMASK) | (ptr_inc & PMASK);

    assign spi_we  = !rst && !cs_rise && !cs_fall && (state == S_WRITE)
                     && sck_rise && byte_done && wel;
    assign load_we = load_en && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (spi_we) begin
            mem[ptr] <= rx_nxt;
        end else if (load_we) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            bitcnt <= 3'd7;
            rx_sh  <= '0;
            tx_sh  <= '0;
            ptr    <= '0;
            wel    <= 1'b0;
            wrote  <= 1'b0;
            is_rd  <= 1'b0;
            armed  <= 1'b0;
        end else if (cs_rise) begin
            state  <= S_IDLE;
            bitcnt <= 3'd7;
            armed  <= 1'b0;
            wrote  <= 1'b0;
            if (state == S_WRITE && wrote) wel <= 1'b0;
        end else if (cs_fall) begin
            state  <= S_CMD;
            bitcnt <= 3'd7;
            armed  <= 1'b0;
            wrote  <= 1'b0;
        end else begin
            unique case (state)
                S_CMD: if (sck_rise) begin
                    rx_sh  <= rx_nxt;
                    bitcnt <= bit_dec;
                    if (byte_done) begin
                        case (rx_nxt)
                            OP_READ: begin
                                is_rd <= 1'b1;
                                state <= S_ADDR;
                            end
                            OP_WRITE: begin
                                is_rd <= 1'b0;
                                state <= S_ADDR;
                            end
                            OP_RDSR: begin
                                tx_sh <= status;
                                state <= S_RDSR;
                            end
                            OP_WREN: begin
                                wel   <= 1'b1;
                                state <= S_IGNORE;
                            end
                            OP_WRDI: begin
                                wel   <= 1'b0;
                                state <= S_IGNORE;
                            end
                            default: state <= S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: if (sck_rise) begin
                    rx_sh  <= rx_nxt;
                    bitcnt <= bit_dec;
                    if (byte_done) begin
                        ptr <= rx_addr;
                        if (is_rd) begin
                            tx_sh <= mem[rx_addr];
                            state <= S_READ;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: if (sck_rise) begin
                    rx_sh  <= rx_nxt;
                    bitcnt <= bit_dec;
                    if (byte_done) begin
                        ptr <= ptr_pg;
                        if (wel) wrote <= 1'b1;
                    end
                end
                // The fall right after the loading rise is not a shift edge;
                // armed ensures only falls following a data-phase rise shift.
                S_READ, S_RDSR: begin
                    if (sck_rise) begin
                        armed <= 1'b1;
                    end else if (sck_fall && armed) begin
                        armed  <= 1'b0;
                        bitcnt <= bit_dec;
                        if (!byte_done) begin
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end else if (state == S_READ) begin
                            ptr   <= ptr_inc;
                            tx_sh <= mem[ptr_inc];
                        end else begin
                            tx_sh <= status;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_cipo_oe = ((state == S_READ) || (state == S_RDSR))
                         && !cs_sy[1];
    assign spi_cipo    = spi_cipo_oe & tx_sh[7];

endmodule
